// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN / ILEN      : address and instruction widths
//   RESET_PC_DEFAULT : first fetch address after reset
//   NOP_INST         : canonical NOP (addi x0,x0,0), used by decode to insert bubbles
//   fetch_entry_t    : one prefetch buffer entry, {pc, inst}
package fetch_prefetch_unit_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INST         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch_entry_t used as the prefetch buffer.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : write push_data at the tail (caller guarantees room)
//   pop               : advance the head (ignored when empty)
//   flush             : empty the FIFO; wins over push and pop
//   head              : entry at the head, meaningful while empty=0
//   count, full, empty: occupancy
module fetch_fifo
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_FULL);
    assign do_pop = pop & ~empty;
    // Storage is cleared on reset so the head reads as all-zero until the first push.
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the PC, issues single-word reads to
// instruction memory (at most one outstanding), buffers returned words with
// their PCs and hands them to decode.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   en                       : fetch enable (buffered entries still drain when low)
//   imem_req, imem_addr      : one-cycle read strobe and word address
//   imem_rvalid, imem_rdata  : read return, one or more cycles after the request
//   redirect, redirect_pc    : flush the buffer, drop in-flight data, restart at redirect_pc
//   inst_valid, inst_ready   : decode handshake
//   inst, inst_pc            : head instruction and its PC
//
// Decode handshake: an instruction transfers in every cycle where
// inst_valid && inst_ready && !redirect; inst/inst_pc hold steady while
// inst_valid is high and no transfer occurs; inst_valid does not wait on inst_ready.
module fetch_prefetch_unit #(
    parameter int XLEN = fetch_prefetch_unit_pkg::XLEN,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = fetch_prefetch_unit_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    import fetch_prefetch_unit_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW+1:0] CN_ONE   = 1;
    localparam logic [PW+1:0] CN_DEPTH = (PW+2)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP  = 4;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;      // address of the read currently outstanding
    logic            outstanding;
    logic            discard;     // outstanding read belongs to a flushed stream

    fetch_entry_t    head;
    fetch_entry_t    push_data;
    logic [PW:0]     fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    logic            push;
    logic            pop;
    logic            issue;
    logic [PW+1:0]   count_next;

    // Redirect cancels both ends of the buffer in its cycle.
    assign push = imem_rvalid & outstanding & ~discard & ~redirect;
    assign pop  = ~fifo_empty & inst_ready & ~redirect;

    always_comb begin
        count_next = {1'b0, fifo_count};
        if (push) count_next = count_next + CN_ONE;
        if (pop)  count_next = count_next - CN_ONE;
    end

    // Issuing only while count_next < DEPTH reserves a slot for the returning
    // word, so the FIFO can never be pushed while full.
    assign issue = ~rst & en & ~redirect & (~outstanding | imem_rvalid) &
                   (count_next < CN_DEPTH);

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign push_data.pc   = req_pc;
    assign push_data.inst = imem_rdata;

    assign inst_valid = ~fifo_empty;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_pc & ALIGN_MASK;
            end else if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end

            if (issue) begin
                req_pc <= fetch_pc;
            end

            // A return and a new issue in the same cycle keep outstanding set.
            if (issue) begin
                outstanding <= 1'b1;
            end else if (imem_rvalid) begin
                outstanding <= 1'b0;
            end

            if (outstanding & imem_rvalid) begin
                discard <= 1'b0;
            end
            // Read still in flight across a redirect: its data must not be buffered.
            if (redirect & outstanding & ~imem_rvalid) begin
                discard <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push & (~fifo_full | pop)),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction-fetch front end directly upstream of the control decoder.
- Owns the program counter and issues word reads to instruction memory.
- Buffers returned instructions with their PCs in a small prefetch FIFO.
- Presents them to decode over a valid/ready handshake.
- A redirect input (branch/jal/jalr resolution) flushes the buffer, cancels any in-flight read and restarts fetch at the new PC.

Parameters:
- XLEN, 32, width of PC and instruction word.
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  fetch enable; when low no new reads issue, buffered instructions still drain.
- imem_req  out  1  single-cycle read request strobe.
- imem_addr  out  XLEN  word-aligned read address, valid while imem_req=1.
- imem_rvalid  in  1  read data return strobe, at least 1 cycle after request.
- imem_rdata  in  XLEN  returned instruction word.
- redirect  in  1  flush and restart request.
- redirect_pc  in  XLEN  restart address; bits [1:0] forced to 0.
- inst_valid  out  1  head of FIFO holds an instruction.
- inst_ready  in  1  decoder accepts the head this cycle.
- inst  out  XLEN  instruction at FIFO head.
- inst_pc  out  XLEN  PC of that instruction.

Behaviour:
- Reset values:
  - fetch_pc=RESET_PC, FIFO count=0, outstanding=0, discard=0.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- Reset mid-operation clears all state.
  - Instruction memory shares rst and abandons in-flight reads.
  - imem_rvalid arriving while outstanding=0 is ignored.
- Outstanding reads: at most one.
- Issue condition: en=1, redirect=0, (outstanding=0 or imem_rvalid=1), and count_next < DEPTH.
  - count_next = count + push - pop.
  - This guarantees a FIFO slot for every issued read; the FIFO never overflows.
- On issue:
  - imem_req=1 and imem_addr=fetch_pc, combinational from registered state.
  - fetch_pc += 4 with 32-bit wrap; outstanding=1.
- Push: imem_rvalid=1 and outstanding=1 and discard=0.
  - Writes {fetch address of that read, imem_rdata} at the tail.
  - outstanding clears unless a new issue occurs in the same cycle.
- Pop: inst_valid & inst_ready.
  - inst_valid = (count != 0).
  - inst/inst_pc are driven from the head entry; data is stable while valid and not popped.
- Simultaneous push and pop: count unchanged, both take effect; legal at full and at empty+1.
- Redirect (highest priority, overrides push, pop and issue in that cycle):
  - count=0, fetch_pc={redirect_pc[XLEN-1:2],2'b00}.
  - If outstanding=1 and imem_rvalid=0, discard=1.
  - If imem_rvalid=1 in the redirect cycle, that data is dropped and outstanding=0.
  - inst_valid=0 next cycle.
  - First post-redirect request issues the following cycle.
- Discard handling: the next imem_rvalid with discard=1 is dropped; discard and outstanding clear.
  - An issue may occur in that same cycle if the other issue conditions hold.
- Latency and throughput:
  - With 1-cycle memory and inst_ready=1: first request the cycle after rst deasserts, first inst_valid 2 cycles after that.
  - Sustained rate is 1 instruction/cycle.
  - Redirect-to-first-valid is 3 cycles.
- en deasserted with a read outstanding: the read completes and is pushed normally.

Decomposition:
- Shared package:
  - XLEN/ILEN constants, RESET_PC default.
  - fetch_entry_t typedef {pc, inst}.
  - NOP encoding 32'h0000_0013 for decode-side bubble insertion.
- One sub-module: fetch_fifo, a synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count, full, empty.
  - flush takes priority over push.
- PC, outstanding/discard logic and issue arbitration stay in fetch_prefetch_unit.

Test Plan:
- Reset then en=1, 1-cycle memory, inst_ready=1 -> requests at 0x0,0x4,0x8 on consecutive cycles; inst_pc 0x0 appears 2 cycles after first req; one instruction per cycle thereafter.
- inst_ready=0 for 10 cycles -> exactly DEPTH=4 entries fill (PCs 0x0-0xC); no request while count+outstanding=4; releasing ready resumes at 0x10 in order.
- Redirect to 0x100 while a 3-cycle read of 0x8 is outstanding -> stale 0x8 data dropped; next inst_pc=0x100; no 0x8 ever presented.
- Redirect with redirect_pc=0x203 coincident with imem_rvalid -> returned data dropped; next imem_addr=0x200.
- Assert rst while FIFO holds 3 entries and a read is outstanding -> next cycle inst_valid=0, imem_req=0; after release fetch restarts at RESET_PC.
- fetch_pc=0xFFFF_FFFC, ready=1 -> next request address wraps to 0x0000_0000.
